// File: rtl/flash_bus_arbiter_if.sv
// Purpose: per-master flash bus bundle for flash_bus_arbiter.
//   Master -> arbiter: req, nce, sclk, sout[3:0], oe, bus_qpi
//   Arbiter -> master: gnt
`timescale 1ns/1ps

interface flash_bus_arbiter_if;
    logic       req;
    logic       gnt;
    logic       nce;
    logic       sclk;
    logic [3:0] sout;
    logic       oe;
    logic       bus_qpi;

    modport master (
        output req, nce, sclk, sout, oe, bus_qpi,
        input  gnt
    );

    modport slave (
        input  req, nce, sclk, sout, oe, bus_qpi,
        output gnt
    );
endinterface

// File: rtl/flash_bus_arbiter.sv
// Purpose: shares the single QSPI config flash between the CPU XIP controller (m0)
// and the loader/DFU flash engine (m1). The owner's lines are muxed to the pins,
// non-owners see a parked bus, and a CS-high gap of GAP_CYCLES separates owners.
// Ports:
//   clk, rstn        48 MHz clock, asynchronous active-low reset
//   m0, m1           per-master bundles (req/gnt handshake + flash lines)
//   flash_*          pin-side chip select, clock, data out, output enable, bus mode
//   flash_selected   high while a master owns the bus (drives USRMCLKTS)
//   timeout_evt      one-cycle pulse on a forced revoke
// Optional feature: define FLASH_ARB_TIMEOUT_EN to enable hold-time preemption
// (parameter TIMEOUT_CYCLES); without it timeout_evt is tied low.
`timescale 1ns/1ps

module flash_bus_arbiter #(
    parameter int unsigned GAP_CYCLES = 4
`ifdef FLASH_ARB_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 65536
`endif
) (
    input  logic                clk,
    input  logic                rstn,
    flash_bus_arbiter_if.slave  m0,
    flash_bus_arbiter_if.slave  m1,
    output logic                flash_nce,
    output logic                flash_sclk,
    output logic [3:0]          flash_sout,
    output logic                flash_oe,
    output logic                flash_bus_qpi,
    output logic                flash_selected,
    output logic                timeout_evt
);

    localparam int unsigned GAP_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    state_t             arb_state_c;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic               rr_last_q;
    logic               qpi_q;
    logic               gnt0_q;
    logic               gnt1_q;
    logic               sel_q;
    logic               req0_eff_c;
    logic               req1_eff_c;

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam int unsigned HOLD_W = 17;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TIMEOUT_CYCLES - 1);

    logic [HOLD_W-1:0]  hold_cnt_q;
    logic               blk0_q;
    logic               blk1_q;
    logic               revoke_c;
    logic               evt_q;

    // A revoked master stays masked until it drops its request.
    assign req0_eff_c = m0.req & ~blk0_q;
    assign req1_eff_c = m1.req & ~blk1_q;
`else
    assign req0_eff_c = m0.req;
    assign req1_eff_c = m1.req;
`endif

    // Arbitration result used from IDLE and at the last GAP cycle.
    always_comb begin
        arb_state_c = ST_IDLE;
        if (req0_eff_c && req1_eff_c) begin
            arb_state_c = rr_last_q ? ST_OWN0 : ST_OWN1;
        end else if (req0_eff_c) begin
            arb_state_c = ST_OWN0;
        end else if (req1_eff_c) begin
            arb_state_c = ST_OWN1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
`ifdef FLASH_ARB_TIMEOUT_EN
        revoke_c = 1'b0;
`endif
        case (state_q)
            ST_IDLE: state_d = arb_state_c;
            ST_OWN0: begin
                if (!m0.req) begin
                    state_d = ST_GAP;
`ifdef FLASH_ARB_TIMEOUT_EN
                end else if (m1.req && (hold_cnt_q == HOLD_LAST)) begin
                    state_d  = ST_GAP;
                    revoke_c = 1'b1;
`endif
                end
            end
            ST_OWN1: begin
                if (!m1.req) begin
                    state_d = ST_GAP;
`ifdef FLASH_ARB_TIMEOUT_EN
                end else if (m0.req && (hold_cnt_q == HOLD_LAST)) begin
                    state_d  = ST_GAP;
                    revoke_c = 1'b1;
`endif
                end
            end
            ST_GAP: begin
                if (gap_cnt_q <= GAP_W'(1)) begin
                    state_d = arb_state_c;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pin mux: owner's lines in OWN, parked bus otherwise; bus mode persists.
    always_comb begin
        flash_nce     = 1'b1;
        flash_sclk    = 1'b0;
        flash_sout    = 4'h0;
        flash_oe      = 1'b0;
        flash_bus_qpi = qpi_q;
        case (state_q)
            ST_OWN0: begin
                flash_nce     = m0.nce;
                flash_sclk    = m0.sclk;
                flash_sout    = m0.sout;
                flash_oe      = m0.oe;
                flash_bus_qpi = m0.bus_qpi;
            end
            ST_OWN1: begin
                flash_nce     = m1.nce;
                flash_sclk    = m1.sclk;
                flash_sout    = m1.sout;
                flash_oe      = m1.oe;
                flash_bus_qpi = m1.bus_qpi;
            end
            default: ;
        endcase
    end

    // Gap counter, round-robin history, bus-mode memory and registered status.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gap_cnt_q <= '0;
            rr_last_q <= 1'b1;
            qpi_q     <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            sel_q     <= 1'b0;
        end else begin
            if ((state_d == ST_GAP) && (state_q != ST_GAP)) begin
                gap_cnt_q <= GAP_W'(GAP_CYCLES);
            end else if (state_q == ST_GAP) begin
                gap_cnt_q <= gap_cnt_q - GAP_W'(1);
            end

            if ((state_d == ST_OWN0) && (state_q != ST_OWN0)) begin
                rr_last_q <= 1'b0;
            end else if ((state_d == ST_OWN1) && (state_q != ST_OWN1)) begin
                rr_last_q <= 1'b1;
            end

            if (state_q == ST_OWN0) begin
                qpi_q <= m0.bus_qpi;
            end else if (state_q == ST_OWN1) begin
                qpi_q <= m1.bus_qpi;
            end

            gnt0_q <= (state_d == ST_OWN0);
            gnt1_q <= (state_d == ST_OWN1);
            sel_q  <= (state_d == ST_OWN0) || (state_d == ST_OWN1);
        end
    end

`ifdef FLASH_ARB_TIMEOUT_EN
    // Hold timer: runs while the owner keeps the other master waiting.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_cnt_q <= '0;
            blk0_q     <= 1'b0;
            blk1_q     <= 1'b0;
            evt_q      <= 1'b0;
        end else begin
            if (((state_q == ST_OWN0) && m1.req) || ((state_q == ST_OWN1) && m0.req)) begin
                hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
            end else if ((state_q == ST_IDLE) || (state_q == ST_GAP)) begin
                hold_cnt_q <= '0;
            end

            if (revoke_c && (state_q == ST_OWN0)) begin
                blk0_q <= 1'b1;
            end else if (!m0.req) begin
                blk0_q <= 1'b0;
            end

            if (revoke_c && (state_q == ST_OWN1)) begin
                blk1_q <= 1'b1;
            end else if (!m1.req) begin
                blk1_q <= 1'b0;
            end

            evt_q <= revoke_c;
        end
    end

    assign timeout_evt = evt_q;
`else
    assign timeout_evt = 1'b0;
`endif

    assign m0.gnt         = gnt0_q;
    assign m1.gnt         = gnt1_q;
    assign flash_selected = sel_q;

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// Purpose: self-checking bench for flash_bus_arbiter: cycle-by-cycle vector table
// for grant/gap/pin-mux behaviour plus sequences for reset, tie alternation and
// the hold-time preemption (or its absence in the default build).
`timescale 1ns/1ps

module tb_flash_bus_arbiter;

    logic       clk = 1'b0;
    logic       rstn;
    logic       flash_nce;
    logic       flash_sclk;
    logic [3:0] flash_sout;
    logic       flash_oe;
    logic       flash_bus_qpi;
    logic       flash_selected;
    logic       timeout_evt;

    int checks = 0;
    int errors = 0;

    flash_bus_arbiter_if m0_if ();
    flash_bus_arbiter_if m1_if ();

`ifdef FLASH_ARB_TIMEOUT_EN
    flash_bus_arbiter #(.GAP_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
`else
    flash_bus_arbiter #(.GAP_CYCLES(4)) dut (
`endif
        .clk            (clk),
        .rstn           (rstn),
        .m0             (m0_if),
        .m1             (m1_if),
        .flash_nce      (flash_nce),
        .flash_sclk     (flash_sclk),
        .flash_sout     (flash_sout),
        .flash_oe       (flash_oe),
        .flash_bus_qpi  (flash_bus_qpi),
        .flash_selected (flash_selected),
        .timeout_evt    (timeout_evt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r0;
        logic       r1;
        logic [3:0] s0;
        logic [3:0] s1;
        logic       q0;
        logic       q1;
        logic       g0;
        logic       g1;
        logic       sel;
        logic       nce;
        logic [3:0] sout;
        logic       qpi;
    } vec_t;

    vec_t vt[29];

    function automatic vec_t mk(input logic r0, input logic r1,
                                input logic [3:0] s0, input logic [3:0] s1,
                                input logic q0, input logic q1,
                                input logic g0, input logic g1, input logic sel,
                                input logic nce, input logic [3:0] sout, input logic qpi);
        vec_t v;
        v.r0 = r0;  v.r1 = r1;  v.s0 = s0;   v.s1 = s1;   v.q0 = q0;  v.q1 = q1;
        v.g0 = g0;  v.g1 = g1;  v.sel = sel; v.nce = nce; v.sout = sout; v.qpi = qpi;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic r0, input logic r1);
        m0_if.req = r0;
        m1_if.req = r1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int hi;
        int waited;
        bit got;

        // Masters keep CS low and drive clock/oe high so pin muxing is visible.
        rstn          = 1'b0;
        m0_if.req     = 1'b0; m1_if.req     = 1'b0;
        m0_if.nce     = 1'b0; m1_if.nce     = 1'b0;
        m0_if.sclk    = 1'b1; m1_if.sclk    = 1'b1;
        m0_if.oe      = 1'b1; m1_if.oe      = 1'b1;
        m0_if.sout    = 4'h5; m1_if.sout    = 4'hA;
        m0_if.bus_qpi = 1'b0; m1_if.bus_qpi = 1'b0;

        //         r0 r1 s0    s1    q0 q1 | g0 g1 sel nce sout  qpi
        vt[0]  = mk(0, 1, 4'h5, 4'hA, 0, 0,  0, 1, 1,  0, 4'hA, 0);
        vt[1]  = mk(0, 1, 4'h5, 4'h3, 0, 1,  0, 1, 1,  0, 4'h3, 1);
        vt[2]  = mk(0, 0, 4'h5, 4'h3, 0, 1,  0, 0, 0,  1, 4'h0, 1);
        vt[3]  = mk(0, 0, 4'h5, 4'hA, 0, 0,  0, 0, 0,  1, 4'h0, 1);
        vt[4]  = mk(0, 0, 4'h5, 4'hA, 0, 0,  0, 0, 0,  1, 4'h0, 1);
        vt[5]  = mk(0, 0, 4'h5, 4'hA, 0, 0,  0, 0, 0,  1, 4'h0, 1);
        vt[6]  = mk(0, 0, 4'h5, 4'hA, 0, 0,  0, 0, 0,  1, 4'h0, 1);
        vt[7]  = mk(1, 1, 4'h5, 4'hA, 1, 0,  1, 0, 1,  0, 4'h5, 1);
        vt[8]  = mk(1, 1, 4'hC, 4'hA, 1, 0,  1, 0, 1,  0, 4'hC, 1);
        vt[9]  = mk(0, 1, 4'hC, 4'hA, 1, 0,  0, 0, 0,  1, 4'h0, 1);
        vt[10] = mk(0, 1, 4'h5, 4'hA, 0, 0,  0, 0, 0,  1, 4'h0, 1);
        vt[11] = mk(0, 1, 4'h5, 4'hA, 0, 0,  0, 0, 0,  1, 4'h0, 1);
        vt[12] = mk(0, 1, 4'h5, 4'hA, 0, 0,  0, 0, 0,  1, 4'h0, 1);
        vt[13] = mk(0, 1, 4'h5, 4'hA, 0, 0,  0, 1, 1,  0, 4'hA, 0);
        vt[14] = mk(1, 0, 4'h5, 4'hA, 0, 0,  0, 0, 0,  1, 4'h0, 0);
        vt[15] = mk(1, 0, 4'h5, 4'hA, 0, 0,  0, 0, 0,  1, 4'h0, 0);
        vt[16] = mk(1, 0, 4'h5, 4'hA, 0, 0,  0, 0, 0,  1, 4'h0, 0);
        vt[17] = mk(1, 0, 4'h5, 4'hA, 0, 0,  0, 0, 0,  1, 4'h0, 0);
        vt[18] = mk(1, 0, 4'h5, 4'hA, 1, 0,  1, 0, 1,  0, 4'h5, 1);
        vt[19] = mk(0, 0, 4'h5, 4'hA, 1, 0,  0, 0, 0,  1, 4'h0, 1);
        vt[20] = mk(1, 0, 4'h5, 4'hA, 0, 0,  0, 0, 0,  1, 4'h0, 1);
        vt[21] = mk(1, 0, 4'h5, 4'hA, 0, 0,  0, 0, 0,  1, 4'h0, 1);
        vt[22] = mk(1, 0, 4'h5, 4'hA, 0, 0,  0, 0, 0,  1, 4'h0, 1);
        vt[23] = mk(1, 0, 4'h5, 4'hA, 0, 0,  1, 0, 1,  0, 4'h5, 0);
        vt[24] = mk(0, 0, 4'h5, 4'hA, 0, 0,  0, 0, 0,  1, 4'h0, 0);
        vt[25] = mk(0, 0, 4'h5, 4'hA, 0, 0,  0, 0, 0,  1, 4'h0, 0);
        vt[26] = mk(0, 0, 4'h5, 4'hA, 0, 0,  0, 0, 0,  1, 4'h0, 0);
        vt[27] = mk(0, 0, 4'h5, 4'hA, 0, 0,  0, 0, 0,  1, 4'h0, 0);
        vt[28] = mk(0, 0, 4'h5, 4'hA, 0, 0,  0, 0, 0,  1, 4'h0, 0);

        // Reset values while rstn is low.
        #3;
        chk("rst_gnt0", 32'(m0_if.gnt), 32'd0);
        chk("rst_gnt1", 32'(m1_if.gnt), 32'd0);
        chk("rst_nce", 32'(flash_nce), 32'd1);
        chk("rst_sclk", 32'(flash_sclk), 32'd0);
        chk("rst_sout", 32'(flash_sout), 32'd0);
        chk("rst_oe", 32'(flash_oe), 32'd0);
        chk("rst_qpi", 32'(flash_bus_qpi), 32'd0);
        chk("rst_sel", 32'(flash_selected), 32'd0);
        chk("rst_evt", 32'(timeout_evt), 32'd0);
        tick();
        tick();
        rstn = 1'b1;

        // Cycle-by-cycle vector table.
        for (int i = 0; i < 29; i++) begin
            set_req(vt[i].r0, vt[i].r1);
            m0_if.sout    = vt[i].s0;
            m1_if.sout    = vt[i].s1;
            m0_if.bus_qpi = vt[i].q0;
            m1_if.bus_qpi = vt[i].q1;
            tick();
            chk($sformatf("v%0d_gnt0", i), 32'(m0_if.gnt), 32'(vt[i].g0));
            chk($sformatf("v%0d_gnt1", i), 32'(m1_if.gnt), 32'(vt[i].g1));
            chk($sformatf("v%0d_sel", i), 32'(flash_selected), 32'(vt[i].sel));
            chk($sformatf("v%0d_nce", i), 32'(flash_nce), 32'(vt[i].nce));
            chk($sformatf("v%0d_sclk", i), 32'(flash_sclk), 32'(!vt[i].nce));
            chk($sformatf("v%0d_oe", i), 32'(flash_oe), 32'(!vt[i].nce));
            chk($sformatf("v%0d_sout", i), 32'(flash_sout), 32'(vt[i].sout));
            chk($sformatf("v%0d_qpi", i), 32'(flash_bus_qpi), 32'(vt[i].qpi));
            chk($sformatf("v%0d_evt", i), 32'(timeout_evt), 32'd0);
        end

        // Asynchronous reset in the middle of an OWN0 transfer.
        m0_if.sout = 4'h5;
        set_req(1'b1, 1'b0);
        tick();
        chk("pre_rst_gnt0", 32'(m0_if.gnt), 32'd1);
        chk("pre_rst_nce", 32'(flash_nce), 32'd0);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_nce", 32'(flash_nce), 32'd1);
        chk("mid_rst_gnt0", 32'(m0_if.gnt), 32'd0);
        chk("mid_rst_sel", 32'(flash_selected), 32'd0);
        chk("mid_rst_sout", 32'(flash_sout), 32'd0);
        tick();
        set_req(1'b0, 1'b0);
        rstn = 1'b1;
        tick();
        chk("post_rst_sel", 32'(flash_selected), 32'd0);

        // Repeated ties from IDLE alternate 0,1,0,1.
        for (int k = 0; k < 4; k++) begin
            set_req(1'b1, 1'b1);
            tick();
            chk($sformatf("tie%0d_gnt0", k), 32'(m0_if.gnt), 32'((k % 2) == 0));
            chk($sformatf("tie%0d_gnt1", k), 32'(m1_if.gnt), 32'((k % 2) == 1));
            set_req(1'b0, 1'b0);
            repeat (5) tick();
            chk($sformatf("tie%0d_idle_nce", k), 32'(flash_nce), 32'd1);
            chk($sformatf("tie%0d_idle_sel", k), 32'(flash_selected), 32'd0);
        end

`ifdef FLASH_ARB_TIMEOUT_EN
        // rr_last is 1 after four ties, so m0 wins; m1 waits until the hold timer fires.
        set_req(1'b1, 1'b1);
        tick();
        chk("to_gnt0_first", 32'(m0_if.gnt), 32'd1);
        hi = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (m0_if.gnt) hi++;
            else break;
        end
        chk("to_hold_cycles", 32'(hi), 32'd16);
        chk("to_evt_pulse", 32'(timeout_evt), 32'd1);
        chk("to_nce_forced", 32'(flash_nce), 32'd1);
        tick();
        chk("to_evt_clear", 32'(timeout_evt), 32'd0);
        got = 1'b0;
        waited = 0;
        for (int i = 0; i < 10; i++) begin
            if (m1_if.gnt) begin
                got = 1'b1;
                break;
            end
            tick();
            waited++;
        end
        chk("to_gnt1_after_gap", 32'(got), 32'd1);
        chk("to_gap_wait", 32'(waited), 32'd3);
        chk("to_gnt0_revoked", 32'(m0_if.gnt), 32'd0);
        // m0 still holds req high but must re-raise it to be heard.
        set_req(1'b1, 1'b0);
        repeat (6) tick();
        chk("to_blocked_gnt0", 32'(m0_if.gnt), 32'd0);
        set_req(1'b0, 1'b0);
        tick();
        set_req(1'b1, 1'b0);
        tick();
        chk("to_reraise_gnt0", 32'(m0_if.gnt), 32'd1);
        set_req(1'b0, 1'b0);
        repeat (6) tick();
`else
        // No preemption: m0 keeps the bus however long m1 waits.
        set_req(1'b1, 1'b1);
        tick();
        for (int i = 0; i < 1000; i++) begin
            chk("nto_gnt0_held", 32'(m0_if.gnt), 32'd1);
            chk("nto_evt_low", 32'(timeout_evt), 32'd0);
            tick();
        end
        chk("nto_gnt1_low", 32'(m1_if.gnt), 32'd0);
        set_req(1'b0, 1'b0);
        repeat (6) tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
